pipe_stage_regs: RTL
====================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall_f, stall_d, flush_d, flush_e  in  1 each  stage control from hazard unit.
REQ-004 SHALL have ports: forward_operand_a_e, forward_operand_b_e  in  2 each  operand select from hazard unit.
REQ-005 SHALL have port: pc_next_f  in  32  next PC value.
REQ-006 SHALL have port: instr_f  in  32  fetched instruction.
REQ-007 SHALL have ports: rd1_d, rd2_d  in  32 each  register-file read data.
REQ-008 SHALL have ports: regwrite_d, memwrite_d  in  1 each;  result_src_d  in  2  decode controls.
REQ-009 SHALL have port: alu_result_e  in  32  combinational ALU output of execute.
REQ-010 SHALL have port: read_data_m  in  32  data-memory read data.
REQ-011 SHALL have ports: pc_f  out  32;  instr_d  out  32.
REQ-012 SHALL have ports: rs1_d, rs2_d  out  5 each  = instr_d[19:15], instr_d[24:20], combinational.
REQ-013 SHALL have ports: rs1_e, rs2_e, rd_e  out  5 each;  result_src_e_0  out  1.
REQ-014 SHALL have ports: src_a_e, src_b_e  out  32 each  forwarded operands.
REQ-015 SHALL have ports: rd_m  out  5;  regwrite_m, memwrite_m  out  1;  alu_result_m, write_data_m  out  32.
REQ-016 SHALL have ports: rd_w  out  5;  regwrite_w  out  1;  result_w  out  32.

Function
REQ-017 PC register SHALL load pc_next_f each cycle unless stall_f=1, then hold.
REQ-018 F/D register (instr_d) SHALL: flush_d=1 -> 0; else stall_d=1 -> hold; else load instr_f; flush_d has priority over stall_d.
REQ-019 D/E register SHALL capture rd1_d, rd2_d, rs1_d, rs2_d, rd (instr_d[11:7]), regwrite_d, memwrite_d, result_src_d every cycle; flush_e=1 -> all fields 0 (bubble).
REQ-020 D/E register SHALL never stall; result_src_e_0 = result_src_e[0].
REQ-021 src_a_e mux: forward_operand_a_e 00 -> rd1_e, 01 -> alu_result_m, 10 -> result_w, 11 -> rd1_e; src_b_e identical using forward_operand_b_e and rd2_e.
REQ-022 E/M register SHALL capture rd_e, regwrite_e, memwrite_e, result_src_e, alu_result_e, src_b_e (as write_data_m) every cycle, no stall or flush.
REQ-023 M/W register SHALL capture rd_m, regwrite_m, result_src_m, alu_result_m, read_data_m every cycle, no stall or flush.
REQ-024 result_w SHALL be combinational: result_src_w=01 -> read_data_w, otherwise alu_result_w.
REQ-025 Latency: instruction in D at cycle n SHALL be in E at n+1, M at n+2, W at n+3 absent flush.
REQ-026 Writes with rd=0 SHALL propagate unmodified; x0 masking is the hazard unit's job.
REQ-027 stall_d=1 with flush_e=1 (load-use) SHALL hold instr_d and insert exactly one bubble in E.

Reset
REQ-028 reset=1 at a rising edge SHALL zero every register (pc_f, instr_d, all D/E, E/M, M/W fields) and SHALL override stall and flush inputs, including mid-stall.
REQ-029 After reset all outputs SHALL be 0 except combinational outputs, which follow zeroed state (src_a_e=src_b_e=0 with forward 00).

Verification
REQ-030 Reset: assert reset one cycle with stall_f=1 -> pc_f=0, instr_d=0, regwrite_m=regwrite_w=0 next cycle.
REQ-031 Flow: instr_f=0x00500093 (addi x1,x0,5), regwrite_d=1 -> rd_e=1 at n+1, rd_m=1 at n+2, rd_w=1 and regwrite_w=1 at n+3.
REQ-032 Load-use: stall_f=stall_d=flush_e=1 one cycle -> pc_f and instr_d hold, rd_e=0 and regwrite_e path bubble, resume next cycle.
REQ-033 Forwarding: rd1_e=0x11, alu_result_m=0x22, result_w=0x33 -> forward_a 00/01/10/11 gives src_a_e 0x11/0x22/0x33/0x11.
REQ-034 Branch: flush_d=flush_e=stall_d=1 -> instr_d=0 next cycle, D/E fields zero.
REQ-035 Load writeback: result_src_d=01, read_data_m=0xDEADBEEF -> result_w=0xDEADBEEF at W; result_src 00 -> result_w=alu_result_w.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// ----------------------------------------------------------------------------
// pipe_stage_regs
//   Pipeline registers for a five-stage RISC-V style core: PC, F/D, D/E, E/M
//   and M/W, plus the execute-stage operand forwarding muxes and the
//   writeback result mux.
//
// Ports
//   clk                       sole clock, all state updates on rising edge
//   reset                     synchronous active-high reset, zeroes all state
//   stall_f, stall_d          hold PC / F/D register (from hazard unit)
//   flush_d, flush_e          clear F/D / D/E register (from hazard unit)
//   forward_operand_a_e/_b_e  execute operand select: 00/11 reg, 01 M, 10 W
//   pc_next_f, instr_f        fetch stage next PC and fetched instruction
//   rd1_d, rd2_d              register-file read data in decode
//   regwrite_d, memwrite_d,
//   result_src_d              decode control bits
//   alu_result_e              combinational ALU result of execute
//   read_data_m               data-memory read data
//   pc_f, instr_d             PC register and decode instruction
//   rs1_d, rs2_d              source register fields of instr_d
//   rs1_e, rs2_e, rd_e,
//   result_src_e_0            execute stage register fields
//   src_a_e, src_b_e          forwarded execute operands
//   rd_m, regwrite_m, memwrite_m, alu_result_m, write_data_m   memory stage
//   rd_w, regwrite_w, result_w                                 writeback stage
// ----------------------------------------------------------------------------
module pipe_stage_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        flush_e,
    input  logic [1:0]  forward_operand_a_e,
    input  logic [1:0]  forward_operand_b_e,
    input  logic [31:0] pc_next_f,
    input  logic [31:0] instr_f,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic        regwrite_d,
    input  logic        memwrite_d,
    input  logic [1:0]  result_src_d,
    input  logic [31:0] alu_result_e,
    input  logic [31:0] read_data_m,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [4:0]  rs1_d,
    output logic [4:0]  rs2_d,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        result_src_e_0,
    output logic [31:0] src_a_e,
    output logic [31:0] src_b_e,
    output logic [4:0]  rd_m,
    output logic        regwrite_m,
    output logic        memwrite_m,
    output logic [31:0] alu_result_m,
    output logic [31:0] write_data_m,
    output logic [4:0]  rd_w,
    output logic        regwrite_w,
    output logic [31:0] result_w
);

    // Fetch / decode
    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;

    // Decode -> execute
    logic [31:0] r_rd1_e;
    logic [31:0] r_rd2_e;
    logic [4:0]  r_rs1_e;
    logic [4:0]  r_rs2_e;
    logic [4:0]  r_rd_e;
    logic        r_regwrite_e;
    logic        r_memwrite_e;
    logic [1:0]  r_result_src_e;

    // Execute -> memory
    logic [4:0]  r_rd_m;
    logic        r_regwrite_m;
    logic        r_memwrite_m;
    logic [1:0]  r_result_src_m;
    logic [31:0] r_alu_result_m;
    logic [31:0] r_write_data_m;

    // Memory -> writeback
    logic [4:0]  r_rd_w;
    logic        r_regwrite_w;
    logic [1:0]  r_result_src_w;
    logic [31:0] r_alu_result_w;
    logic [31:0] r_read_data_w;

    // Forwarding: index 0 is operand A, index 1 is operand B
    logic [1:0]  w_fwd_sel [2];
    logic [31:0] w_reg_e   [2];
    logic [31:0] w_src_e   [2];
    logic [31:0] w_result_w;
    logic [4:0]  w_rs1_d;
    logic [4:0]  w_rs2_d;

    assign w_rs1_d = r_instr_d[19:15];
    assign w_rs2_d = r_instr_d[24:20];

    // Load data only when the writeback source selects memory; everything
    // else (including the unused 1x codes) returns the ALU result.
    assign w_result_w = (r_result_src_w == 2'b01) ? r_read_data_w : r_alu_result_w;

    assign w_fwd_sel[0] = forward_operand_a_e;
    assign w_fwd_sel[1] = forward_operand_b_e;
    assign w_reg_e[0]   = r_rd1_e;
    assign w_reg_e[1]   = r_rd2_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // 11 is treated like 00 so a stray select can never pick garbage
            assign w_src_e[gi] = (w_fwd_sel[gi] == 2'b01) ? r_alu_result_m :
                                 (w_fwd_sel[gi] == 2'b10) ? w_result_w     :
                                                            w_reg_e[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset beats every stall/flush request.
            r_pc_f         <= '0;
            r_instr_d      <= '0;
            r_rd1_e        <= '0;
            r_rd2_e        <= '0;
            r_rs1_e        <= '0;
            r_rs2_e        <= '0;
            r_rd_e         <= '0;
            r_regwrite_e   <= 1'b0;
            r_memwrite_e   <= 1'b0;
            r_result_src_e <= '0;
            r_rd_m         <= '0;
            r_regwrite_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_result_src_m <= '0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_rd_w         <= '0;
            r_regwrite_w   <= 1'b0;
            r_result_src_w <= '0;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
        end else begin
            if (!stall_f) begin
                r_pc_f <= pc_next_f;
            end

            // Flush wins over stall so a taken branch kills a held instruction.
            if (flush_d) begin
                r_instr_d <= '0;
            end else if (!stall_d) begin
                r_instr_d <= instr_f;
            end

            // D/E never stalls; a load-use stall inserts its bubble here.
            if (flush_e) begin
                r_rd1_e        <= '0;
                r_rd2_e        <= '0;
                r_rs1_e        <= '0;
                r_rs2_e        <= '0;
                r_rd_e         <= '0;
                r_regwrite_e   <= 1'b0;
                r_memwrite_e   <= 1'b0;
                r_result_src_e <= '0;
            end else begin
                r_rd1_e        <= rd1_d;
                r_rd2_e        <= rd2_d;
                r_rs1_e        <= w_rs1_d;
                r_rs2_e        <= w_rs2_d;
                r_rd_e         <= r_instr_d[11:7];
                r_regwrite_e   <= regwrite_d;
                r_memwrite_e   <= memwrite_d;
                r_result_src_e <= result_src_d;
            end

            // Store data is the forwarded B operand, not the raw rd2.
            r_rd_m         <= r_rd_e;
            r_regwrite_m   <= r_regwrite_e;
            r_memwrite_m   <= r_memwrite_e;
            r_result_src_m <= r_result_src_e;
            r_alu_result_m <= alu_result_e;
            r_write_data_m <= w_src_e[1];

            r_rd_w         <= r_rd_m;
            r_regwrite_w   <= r_regwrite_m;
            r_result_src_w <= r_result_src_m;
            r_alu_result_w <= r_alu_result_m;
            r_read_data_w  <= read_data_m;
        end
    end

    assign pc_f           = r_pc_f;
    assign instr_d        = r_instr_d;
    assign rs1_d          = w_rs1_d;
    assign rs2_d          = w_rs2_d;
    assign rs1_e          = r_rs1_e;
    assign rs2_e          = r_rs2_e;
    assign rd_e           = r_rd_e;
    assign result_src_e_0 = r_result_src_e[0];
    assign src_a_e        = w_src_e[0];
    assign src_b_e        = w_src_e[1];
    assign rd_m           = r_rd_m;
    assign regwrite_m     = r_regwrite_m;
    assign memwrite_m     = r_memwrite_m;
    assign alu_result_m   = r_alu_result_m;
    assign write_data_m   = r_write_data_m;
    assign rd_w           = r_rd_w;
    assign regwrite_w     = r_regwrite_w;
    assign result_w       = w_result_w;

endmodule
